// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - ALU opcode, writeback select and bubble encodings for the ID/EX stage
`ifndef ID_EX_DEFINES_SVH
`define ID_EX_DEFINES_SVH
`define ADD 4'h0
`define SUB 4'h1
`define AND 4'h2
`define OR  4'h3
`define XOR 4'h4
`define SLL 4'h5
`define SRL 4'h6
`define SRA 4'h7
`define LUI 4'h8
`define WB_ALU 2'd0
`define WB_MEM 2'd1
`define WB_PC4 2'd2
`endif

package id_ex_reg_pkg;

    localparam logic [3:0] ALU_ADD = `ADD;
    localparam logic [3:0] ALU_SUB = `SUB;
    localparam logic [3:0] ALU_AND = `AND;
    localparam logic [3:0] ALU_OR  = `OR;
    localparam logic [3:0] ALU_XOR = `XOR;
    localparam logic [3:0] ALU_SLL = `SLL;
    localparam logic [3:0] ALU_SRL = `SRL;
    localparam logic [3:0] ALU_SRA = `SRA;
    localparam logic [3:0] ALU_LUI = `LUI;

    typedef enum logic [1:0] {
        WB_SEL_ALU = `WB_ALU,
        WB_SEL_MEM = `WB_MEM,
        WB_SEL_PC4 = `WB_PC4
    } wb_sel_e;

    // A bubble must look like a harmless add that writes nothing.
    localparam logic [3:0] BUBBLE_ALU_SEL = `ADD;
    localparam logic [1:0] BUBBLE_WB_SEL  = `WB_ALU;

endpackage

// File: rtl/id_ex_bypass.sv
// rtl/id_ex_bypass.sv - selects writeback data over an operand when the writeback targets its register
module id_ex_bypass #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] index,
    input  logic [XLEN-1:0] data,
    input  logic            wb_we,
    input  logic [REGW-1:0] wb_wR,
    input  logic [XLEN-1:0] wb_wD,
    output logic [XLEN-1:0] sel_data
);

    logic hit;

    // x0 is hardwired zero, so a write to it must never leak through.
    assign hit      = wb_we && (wb_wR != '0) && (wb_wR == index);
    assign sel_data = hit ? wb_wD : data;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush, writeback bypass and load-use detect
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rD1,
    input  logic [XLEN-1:0] id_rD2,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [XLEN-1:0] id_ext,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_aSel,
    input  logic            id_bSel,
    input  logic [3:0]      id_aluSel,
    input  logic            id_rfWe,
    input  logic            id_memWe,
    input  logic            id_memRe,
    input  logic [1:0]      id_wbSel,
    input  logic            wb_we,
    input  logic [REGW-1:0] wb_wR,
    input  logic [XLEN-1:0] wb_wD,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_data1,
    output logic [XLEN-1:0] ex_data2,
    output logic [XLEN-1:0] ex_sext_imm,
    output logic            ex_aSel,
    output logic            ex_bSel,
    output logic [3:0]      ex_aluSel,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_rfWe,
    output logic            ex_memWe,
    output logic            ex_memRe,
    output logic [1:0]      ex_wbSel,
    output logic            load_use
);

    logic [XLEN-1:0] cap_data1, cap_data2;
    logic [XLEN-1:0] hold_data1, hold_data2;
    logic            load_bubble;

    id_ex_bypass #(.XLEN(XLEN), .REGW(REGW)) u_cap_rs1 (
        .index(id_rs1), .data(id_rD1), .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD), .sel_data(cap_data1)
    );
    id_ex_bypass #(.XLEN(XLEN), .REGW(REGW)) u_cap_rs2 (
        .index(id_rs2), .data(id_rD2), .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD), .sel_data(cap_data2)
    );
    id_ex_bypass #(.XLEN(XLEN), .REGW(REGW)) u_hold_rs1 (
        .index(ex_rs1), .data(ex_data1), .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD), .sel_data(hold_data1)
    );
    id_ex_bypass #(.XLEN(XLEN), .REGW(REGW)) u_hold_rs2 (
        .index(ex_rs2), .data(ex_data2), .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD), .sel_data(hold_data2)
    );

    // An invalid decode slot loads the same bubble as reset or flush.
    assign load_bubble = flush || (!stall && !id_valid);

    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_data1    <= '0;
            ex_data2    <= '0;
            ex_sext_imm <= '0;
            ex_aSel     <= 1'b0;
            ex_bSel     <= 1'b0;
            ex_aluSel   <= BUBBLE_ALU_SEL;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rfWe     <= 1'b0;
            ex_memWe    <= 1'b0;
            ex_memRe    <= 1'b0;
            ex_wbSel    <= BUBBLE_WB_SEL;
        end else if (stall) begin
            // Held operands keep tracking writebacks so they are not stale on release.
            if (ex_valid) begin
                ex_data1 <= hold_data1;
                ex_data2 <= hold_data2;
            end
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_data1    <= cap_data1;
            ex_data2    <= cap_data2;
            ex_sext_imm <= id_ext;
            ex_aSel     <= id_aSel;
            ex_bSel     <= id_bSel;
            ex_aluSel   <= id_aluSel;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rfWe     <= id_rfWe;
            ex_memWe    <= id_memWe;
            ex_memRe    <= id_memRe;
            ex_wbSel    <= id_wbSel;
        end
    end

    assign load_use = ex_valid && ex_memRe && (ex_rd != '0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - self-checking bench for id_ex_reg against a behavioural stage model
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rD1, id_rD2, id_ext;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_aSel, id_bSel;
    logic [3:0]  id_aluSel;
    logic        id_rfWe, id_memWe, id_memRe;
    logic [1:0]  id_wbSel;
    logic        wb_we;
    logic [4:0]  wb_wR;
    logic [31:0] wb_wD;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_data1, ex_data2, ex_sext_imm;
    logic        ex_aSel, ex_bSel;
    logic [3:0]  ex_aluSel;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_rfWe, ex_memWe, ex_memRe;
    logic [1:0]  ex_wbSel;
    logic        load_use;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rD1(id_rD1), .id_rD2(id_rD2), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ext(id_ext), .id_rd(id_rd), .id_aSel(id_aSel), .id_bSel(id_bSel),
        .id_aluSel(id_aluSel), .id_rfWe(id_rfWe), .id_memWe(id_memWe), .id_memRe(id_memRe),
        .id_wbSel(id_wbSel), .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_sext_imm(ex_sext_imm), .ex_aSel(ex_aSel), .ex_bSel(ex_bSel), .ex_aluSel(ex_aluSel),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rfWe(ex_rfWe),
        .ex_memWe(ex_memWe), .ex_memRe(ex_memRe), .ex_wbSel(ex_wbSel), .load_use(load_use)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic        a_sel, b_sel;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic        rf_we, mem_we, mem_re;
        logic [1:0]  wb;
    } stage_t;

    stage_t m;
    bit     model_ready = 0;

    function automatic stage_t bubble();
        stage_t b;
        b.valid = 0; b.pc = 0; b.d1 = 0; b.d2 = 0; b.imm = 0;
        b.a_sel = 0; b.b_sel = 0; b.alu = ALU_ADD;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0;
        b.rf_we = 0; b.mem_we = 0; b.mem_re = 0; b.wb = 0;
        return b;
    endfunction

    // Value a register read of index idx observes this cycle given the writeback port.
    function automatic logic [31:0] reg_view(input logic [4:0] idx, input logic [31:0] stale);
        if (wb_we && wb_wR != 0 && wb_wR == idx) return wb_wD;
        return stale;
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            m = bubble();
        end else if (stall) begin
            if (m.valid) begin
                m.d1 = reg_view(m.rs1, m.d1);
                m.d2 = reg_view(m.rs2, m.d2);
            end
        end else if (!id_valid) begin
            m = bubble();
        end else begin
            m.valid = 1; m.pc = id_pc; m.imm = id_ext;
            m.d1 = reg_view(id_rs1, id_rD1);
            m.d2 = reg_view(id_rs2, id_rD2);
            m.a_sel = id_aSel; m.b_sel = id_bSel; m.alu = id_aluSel;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.rf_we = id_rfWe; m.mem_we = id_memWe; m.mem_re = id_memRe; m.wb = id_wbSel;
        end
        model_ready = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            chk("valid",   32'(ex_valid),    32'(m.valid));
            chk("pc",      ex_pc,            m.pc);
            chk("data1",   ex_data1,         m.d1);
            chk("data2",   ex_data2,         m.d2);
            chk("imm",     ex_sext_imm,      m.imm);
            chk("aSel",    32'(ex_aSel),     32'(m.a_sel));
            chk("bSel",    32'(ex_bSel),     32'(m.b_sel));
            chk("aluSel",  32'(ex_aluSel),   32'(m.alu));
            chk("rs1",     32'(ex_rs1),      32'(m.rs1));
            chk("rs2",     32'(ex_rs2),      32'(m.rs2));
            chk("rd",      32'(ex_rd),       32'(m.rd));
            chk("rfWe",    32'(ex_rfWe),     32'(m.rf_we));
            chk("memWe",   32'(ex_memWe),    32'(m.mem_we));
            chk("memRe",   32'(ex_memRe),    32'(m.mem_re));
            chk("wbSel",   32'(ex_wbSel),    32'(m.wb));
            chk("load_use", 32'(load_use),
                32'(m.valid && m.mem_re && m.rd != 0 && id_valid &&
                    (m.rd == id_rs1 || m.rd == id_rs2)));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd,
                             input logic [3:0] alu, input logic rfwe, input logic memwe,
                             input logic memre);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rD1 = d1; id_rs2 = rs2; id_rD2 = d2;
        id_rd = rd; id_aluSel = alu; id_rfWe = rfwe; id_memWe = memwe; id_memRe = memre;
        id_ext = 32'hFFFF_FFF0; id_aSel = 1; id_bSel = 0; id_wbSel = 2'd1;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        set_instr(32'h0000_0444, 5'd6, 32'h1, 5'd6, 32'h2, 5'd7, ALU_XOR, 1, 1, 1);
        wb_we = 1; wb_wR = 5'd6; wb_wD = 32'h99;
        tick(2);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_data1", ex_data1, 32'd0);
        chk("rst_alu", 32'(ex_aluSel), 32'(ALU_ADD));
        chk("rst_load_use", 32'(load_use), 32'd0);

        rst = 0; wb_we = 0; wb_wR = 0; wb_wD = 0;
        set_instr(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd8, ALU_SUB, 1, 0, 0);
        tick(1);
        chk("load_pc", ex_pc, 32'h100);
        chk("load_data1", ex_data1, 32'd5);
        chk("load_data2", ex_data2, 32'd7);
        chk("load_alu", 32'(ex_aluSel), 32'(ALU_SUB));
        chk("load_valid", 32'(ex_valid), 32'd1);

        set_instr(32'h104, 5'd3, 32'h11, 5'd2, 32'd7, 5'd8, ALU_ADD, 1, 0, 0);
        wb_we = 1; wb_wR = 5'd3; wb_wD = 32'hAA;
        tick(1);
        chk("bypass_data1", ex_data1, 32'hAA);
        wb_wR = 5'd0;
        tick(1);
        chk("x0_no_bypass", ex_data1, 32'h11);

        wb_we = 0;
        set_instr(32'h200, 5'd9, 32'h33, 5'd4, 32'h22, 5'd10, ALU_OR, 1, 1, 0);
        tick(1);
        stall = 1; wb_we = 1; wb_wR = 5'd4; wb_wD = 32'h55;
        set_instr(32'hDEAD_0000, 5'd4, 32'hBAD1, 5'd4, 32'hBAD2, 5'd1, ALU_SRA, 0, 0, 0);
        tick(1);
        chk("refresh_data2", ex_data2, 32'h55);
        chk("refresh_data1_kept", ex_data1, 32'h33);
        wb_we = 0;
        tick(2);
        chk("stall_data2", ex_data2, 32'h55);
        chk("stall_pc", ex_pc, 32'h200);
        chk("stall_alu", 32'(ex_aluSel), 32'(ALU_OR));

        flush = 1;
        tick(1);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rfWe", 32'(ex_rfWe), 32'd0);
        chk("flush_memWe", 32'(ex_memWe), 32'd0);
        chk("flush_data1", ex_data1, 32'd0);

        stall = 0; flush = 0; wb_we = 0;
        set_instr(32'h300, 5'd1, 32'h1, 5'd2, 32'h2, 5'd6, ALU_ADD, 1, 0, 1);
        tick(1);
        id_rs1 = 5'd0; id_rs2 = 5'd6; id_valid = 1;
        #1 chk("load_use_hit", 32'(load_use), 32'd1);
        id_valid = 0;
        #1 chk("load_use_invalid", 32'(load_use), 32'd0);
        set_instr(32'h304, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0, ALU_ADD, 1, 0, 1);
        tick(1);
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1 chk("load_use_rd0", 32'(load_use), 32'd0);

        id_valid = 0; id_pc = 32'h308;
        tick(1);
        chk("invalid_valid", 32'(ex_valid), 32'd0);
        chk("invalid_pc", ex_pc, 32'd0);

        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 29) == 0);
            set_instr($urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
                      $urandom, 5'($urandom_range(0, 7)), 4'($urandom_range(0, 8)),
                      1'($urandom), 1'($urandom), 1'($urandom));
            id_valid = ($urandom_range(0, 4) != 0);
            id_ext = $urandom; id_aSel = 1'($urandom); id_bSel = 1'($urandom);
            id_wbSel = 2'($urandom_range(0, 2));
            wb_we = 1'($urandom); wb_wR = 5'($urandom_range(0, 7)); wb_wD = $urandom;
            tick(1);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between decode and the execute-stage ALU. Captures decoded operands and control each cycle.
- Supports stall (hold) and flush (bubble). Bypasses same-cycle writeback data into captured or held operands.
- Flags load-use hazards for the hazard unit.
- All outputs feed the ALU operand muxes and later stages directly.

Parameters:
- XLEN, 32, datapath width for pc, operands and immediate
- REGW, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold current contents
- flush  in  1  load a bubble (branch/jump redirect)
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction pc
- id_rD1, id_rD2  in  XLEN  register file read data
- id_rs1, id_rs2  in  REGW  source register indices
- id_ext  in  XLEN  sign-extended immediate
- id_rd  in  REGW  destination index
- id_aSel  in  1  ALU A select (0 = pc, 1 = rs1 data)
- id_bSel  in  1  ALU B select (1 = immediate, 0 = rs2 data)
- id_aluSel  in  4  ALU opcode
- id_rfWe, id_memWe, id_memRe  in  1  register write / store / load
- id_wbSel  in  2  writeback source select
- wb_we  in  1  writeback enable
- wb_wR  in  REGW  writeback destination
- wb_wD  in  XLEN  writeback data
- ex_valid  out  1  stage valid
- ex_pc, ex_data1, ex_data2, ex_sext_imm  out  XLEN  registered copies to the ALU
- ex_aSel, ex_bSel  out  1  registered selects
- ex_aluSel  out  4  registered opcode
- ex_rs1, ex_rs2, ex_rd  out  REGW  registered indices
- ex_rfWe, ex_memWe, ex_memRe  out  1  registered control
- ex_wbSel  out  2  registered writeback select
- load_use  out  1  combinational hazard flag

Behaviour:
- Priority per rising edge of clk: rst > flush > stall > load.
- rst=1: all outputs zero. ex_aluSel = `ADD. Stage is a bubble.
- flush=1, with or without stall: bubble loaded. Bubble means:
  - valid, rfWe, memWe and memRe are 0.
  - Data fields and indices are 0. aluSel = `ADD. wbSel = 0.
- Load (no stall, no flush): every ex_* field takes its id_* counterpart. ex_valid = id_valid.
- When id_valid=0, the load step produces a bubble instead.
- Capture bypass, during load only:
  - ex_data1 = wb_wD when wb_we & wb_wR!=0 & wb_wR==id_rs1; otherwise id_rD1.
  - ex_data2 is handled identically using id_rs2.
  - This covers a register-file write and read in the same cycle.
- Stall hold: all fields keep their values, except the refresh below.
  - If ex_valid & wb_we & wb_wR!=0 & wb_wR==ex_rs1, ex_data1 <= wb_wD.
  - ex_data2 is refreshed the same way using ex_rs2.
  - Both operands refresh in the same cycle if both indices match.
- x0 writes are never bypassed or refreshed.
- load_use = ex_valid & ex_memRe & ex_rd!=0 & ((ex_rd==id_rs1) | (ex_rd==id_rs2)) & id_valid.
  - Purely combinational from registered state and id inputs. No internal state.
- Latency: one cycle from id_* to ex_*. Outputs are registered only; nothing combinational from id_* to ex_*.
- Reset or flush during a stall discards the held instruction. No state is retained.

Decomposition:
- Shared defines header owns the 4-bit ALU opcode macros (`ADD, `SUB, `AND, `OR, `XOR, `SLL, `SRL, `SRA, `LUI).
- The same header owns the wbSel encodings and the bubble opcode constant (`ADD).
- One sub-module is natural: id_ex_bypass.
  - Inputs: index, data, wb_we, wb_wR, wb_wD. Output: selected data.
  - Instantiated four times: capture rs1/rs2 and hold rs1/rs2.

Test Plan:
- Reset: rst=1 for 2 cycles with id inputs driven nonzero -> all ex_* = 0, ex_aluSel=`ADD, load_use=0.
- Plain load: id_pc=0x100, id_rD1=5, id_rD2=7, id_aluSel=`SUB, id_rfWe=1 -> next cycle ex_pc=0x100, ex_data1=5, ex_data2=7, ex_aluSel=`SUB, ex_valid=1.
- Capture bypass: id_rs1=3, id_rD1=0x11, wb_we=1, wb_wR=3, wb_wD=0xAA -> ex_data1=0xAA.
- Same stimulus with wb_wR=0 -> ex_data1=0x11.
- Stall refresh: hold an instruction with ex_rs2=4, stall=1. Present wb_we=1, wb_wR=4, wb_wD=0x55 -> ex_data2 becomes 0x55; every other field is unchanged across 3 stall cycles.
- Flush over stall: stall=1 and flush=1 together -> ex_valid=0, ex_rfWe=0, ex_memWe=0, ex_data1=0 next cycle.
- Load-use: ex_memRe=1, ex_rd=6, ex_valid=1 with id_rs2=6, id_valid=1 -> load_use=1.
  - Change to ex_rd=0 -> load_use=0.
  - Change to id_valid=0 -> load_use=0.
